// File: rtl/obstacle_pkg.sv
// rtl/obstacle_pkg.sv - shared state encoding, sensor timing defaults and width helper
package obstacle_pkg;

    localparam int DIST_W          = 8;

    localparam int TRIG_MIN_CYC    = 100;
    localparam int BURST_DELAY_CYC = 4600;
    localparam int CYC_PER_CM      = 580;
    localparam int MAX_CM          = 200;
    localparam int TIMEOUT_CYC     = 380000;
    localparam int HOLDOFF_CYC     = 1000;

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        DELAY,
        ECHO,
        HOLDOFF
    } state_t;

    // Bits needed to hold max_count, never less than one.
    function automatic int cnt_w(input int max_count);
        return (max_count <= 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/ultrasonic_echo_emulator_if.sv
// rtl/ultrasonic_echo_emulator_if.sv - trigger/echo interface between detector and sensor
interface ultrasonic_echo_emulator_if;
    import obstacle_pkg::*;

    logic              ena;
    logic              trig_i;
    logic [DIST_W-1:0] dist_cm_i;
    logic              echo_o;
    logic              busy_o;
    logic              done_o;
    logic              short_trig_o;

    modport master (
        output ena, trig_i, dist_cm_i,
        input  echo_o, busy_o, done_o, short_trig_o
    );

    modport slave (
        input  ena, trig_i, dist_cm_i,
        output echo_o, busy_o, done_o, short_trig_o
    );

endinterface

// File: rtl/echo_down_counter.sv
// rtl/echo_down_counter.sv - loadable down-counter with enable and zero flag
module echo_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    // Load wins over enable; the count parks at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ultrasonic_echo_emulator.sv
// rtl/ultrasonic_echo_emulator.sv - HC-SR04 style sensor model returning a distance-coded echo
module ultrasonic_echo_emulator
    import obstacle_pkg::*;
#(
    parameter int TRIG_MIN_CYC    = obstacle_pkg::TRIG_MIN_CYC,
    parameter int BURST_DELAY_CYC = obstacle_pkg::BURST_DELAY_CYC,
    parameter int CYC_PER_CM      = obstacle_pkg::CYC_PER_CM,
    parameter int MAX_CM          = obstacle_pkg::MAX_CM,
    parameter int TIMEOUT_CYC     = obstacle_pkg::TIMEOUT_CYC,
    parameter int HOLDOFF_CYC     = obstacle_pkg::HOLDOFF_CYC
) (
    input logic                       clk,
    input logic                       rst_n,
    ultrasonic_echo_emulator_if.slave bus
);

    localparam int WCNT_W = cnt_w(TRIG_MIN_CYC);
    localparam int SUB_W  = cnt_w(CYC_PER_CM - 1);
    localparam int DLY_W  = cnt_w(BURST_DELAY_CYC - 1);
    localparam int TO_W   = cnt_w(TIMEOUT_CYC - 1);
    localparam int HO_W   = cnt_w(HOLDOFF_CYC - 1);

    state_t            state_q, state_d;
    logic              trig_q;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [DIST_W-1:0] dist_q;
    logic              done_q, done_d;
    logic              short_q, short_d;
    logic              latch_dist;

    logic delay_load, delay_en, delay_zero;
    logic cm_load, cm_en, cm_zero;
    logic to_load, to_en, to_zero;
    logic hold_load, hold_en, hold_zero;

    logic rise, fall, in_range, sub_last, echo_end;

    assign rise     = bus.trig_i & ~trig_q;
    assign fall     = ~bus.trig_i & trig_q;
    assign in_range = (dist_q != '0) && (int'(dist_q) <= MAX_CM);
    assign sub_last = (sub_q == SUB_W'(CYC_PER_CM - 1));

    // The cm counter holds the whole centimetres still to go after the current one.
    assign echo_end = in_range ? (sub_last && cm_zero) : to_zero;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            trig_q  <= 1'b0;
            wcnt_q  <= '0;
            sub_q   <= '0;
            dist_q  <= '0;
            done_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            trig_q  <= bus.trig_i;
            wcnt_q  <= wcnt_d;
            sub_q   <= sub_d;
            done_q  <= done_d;
            short_q <= short_d;
            if (latch_dist) begin
                dist_q <= bus.dist_cm_i;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        sub_d      = sub_q;
        done_d     = 1'b0;
        short_d    = 1'b0;
        latch_dist = 1'b0;
        delay_load = 1'b0;
        delay_en   = 1'b0;
        cm_load    = 1'b0;
        cm_en      = 1'b0;
        to_load    = 1'b0;
        to_en      = 1'b0;
        hold_load  = 1'b0;
        hold_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = TRIG_HI;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            TRIG_HI: begin
                if (fall) begin
                    if (wcnt_q >= WCNT_W'(TRIG_MIN_CYC)) begin
                        state_d    = DELAY;
                        latch_dist = 1'b1;
                        delay_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        short_d = 1'b1;
                    end
                end else if (wcnt_q < WCNT_W'(TRIG_MIN_CYC)) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            DELAY: begin
                if (delay_zero) begin
                    state_d = ECHO;
                    sub_d   = '0;
                    cm_load = in_range;
                    to_load = ~in_range;
                end else begin
                    delay_en = 1'b1;
                end
            end
            ECHO: begin
                if (echo_end) begin
                    state_d   = HOLDOFF;
                    done_d    = 1'b1;
                    hold_load = 1'b1;
                end else if (in_range) begin
                    sub_d = sub_last ? '0 : sub_q + SUB_W'(1);
                    cm_en = sub_last;
                end else begin
                    to_en = 1'b1;
                end
            end
            HOLDOFF: begin
                if (hold_zero) begin
                    state_d = IDLE;
                end else begin
                    hold_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!bus.ena) begin
            state_d = IDLE;
            done_d  = 1'b0;
            short_d = 1'b0;
        end
    end

    echo_down_counter #(.W(DLY_W)) u_delay_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (delay_load),
        .load_value (DLY_W'(BURST_DELAY_CYC - 1)),
        .en         (delay_en),
        .zero       (delay_zero)
    );

    echo_down_counter #(.W(DIST_W)) u_cm_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cm_load),
        .load_value (dist_q - DIST_W'(1)),
        .en         (cm_en),
        .zero       (cm_zero)
    );

    echo_down_counter #(.W(TO_W)) u_timeout_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (to_load),
        .load_value (TO_W'(TIMEOUT_CYC - 1)),
        .en         (to_en),
        .zero       (to_zero)
    );

    echo_down_counter #(.W(HO_W)) u_holdoff_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (hold_load),
        .load_value (HO_W'(HOLDOFF_CYC - 1)),
        .en         (hold_en),
        .zero       (hold_zero)
    );

    assign bus.echo_o       = (state_q == ECHO);
    assign bus.busy_o       = (state_q == DELAY) || (state_q == ECHO) || (state_q == HOLDOFF);
    assign bus.done_o       = done_q;
    assign bus.short_trig_o = short_q;

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// tb/tb_ultrasonic_echo_emulator.sv - randomized self-checking bench against a timing model
module tb_ultrasonic_echo_emulator;

    localparam int T_MIN = 4;
    localparam int T_DLY = 8;
    localparam int CPC   = 3;
    localparam int MAXC  = 20;
    localparam int TOUT  = 100;
    localparam int T_HO  = 10;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ultrasonic_echo_emulator_if bus ();

    ultrasonic_echo_emulator #(
        .TRIG_MIN_CYC    (T_MIN),
        .BURST_DELAY_CYC (T_DLY),
        .CYC_PER_CM      (CPC),
        .MAX_CM          (MAXC),
        .TIMEOUT_CYC     (TOUT),
        .HOLDOFF_CYC     (T_HO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log: edge index at which each output transition became visible.
    int n_rise = 0, n_done = 0, n_short = 0, n_busy_rise = 0;
    int rise_cyc = -1, fall_cyc = -1, done_cyc = -1, busy_rise_cyc = -1, busy_fall_cyc = -1;
    logic echo_prev = 1'b0, busy_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.echo_o && !echo_prev) begin n_rise++; rise_cyc = cyc; end
        if (!bus.echo_o && echo_prev) fall_cyc = cyc;
        if (bus.done_o) begin n_done++; done_cyc = cyc; end
        if (bus.short_trig_o) n_short++;
        if (bus.busy_o && !busy_prev) begin n_busy_rise++; busy_rise_cyc = cyc; end
        if (!bus.busy_o && busy_prev) busy_fall_cyc = cyc;
        echo_prev = bus.echo_o;
        busy_prev = bus.busy_o;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_width(input int d);
        if (d >= 1 && d <= MAXC) return d * CPC;
        return TOUT;
    endfunction

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Trigger high for n sampling edges; returns the edge that sees the fall.
    task automatic drive_trig(input int n, output int e_fall);
        bus.trig_i = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        bus.trig_i = 1'b0;
        e_fall = cyc + 1;
    endtask

    task automatic run_trial(input int n, input int d, input bit chg, input bit retrig);
        int e, tmp, w, rise_p, fall_p, end_p;
        int b_rise, b_done, b_short, b_busy;
        b_rise = n_rise; b_done = n_done; b_short = n_short; b_busy = n_busy_rise;
        bus.dist_cm_i = 8'(d);
        drive_trig(n, e);
        w      = model_width(d);
        rise_p = e + T_DLY;
        fall_p = rise_p + w;
        end_p  = fall_p + T_HO;
        if (n >= T_MIN) begin
            wait_until(rise_p + 1);
            if (chg) bus.dist_cm_i = 8'($urandom_range(0, 255));
            if (retrig && w >= 20) begin
                wait_until(rise_p + 2);
                drive_trig(5, tmp);
                wait_until(fall_p);
                drive_trig(5, tmp);
            end
            wait_until(end_p + 3);
            check("echo_count", n_rise - b_rise, 1);
            check("echo_rise", rise_cyc, rise_p);
            check("echo_fall", fall_cyc, fall_p);
            check("done_count", n_done - b_done, 1);
            check("done_cyc", done_cyc, fall_p);
            check("busy_rise", busy_rise_cyc, e);
            check("busy_fall", busy_fall_cyc, end_p);
            check("no_short", n_short - b_short, 0);
        end else begin
            wait_until(e + T_DLY + 4);
            check("short_count", n_short - b_short, 1);
            check("short_no_echo", n_rise - b_rise, 0);
            check("short_no_busy", n_busy_rise - b_busy, 0);
            check("short_no_done", n_done - b_done, 0);
        end
    endtask

    initial begin
        int e, n, d;
        rst_n = 1'b0;
        bus.ena = 1'b1;
        bus.trig_i = 1'b1;
        bus.dist_cm_i = 8'd3;
        repeat (3) @(posedge clk);
        #1;
        check("rst_echo", int'(bus.echo_o), 0);
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_done", int'(bus.done_o), 0);
        check("rst_short", int'(bus.short_trig_o), 0);

        // Trigger already high when reset releases counts as a rise.
        rst_n = 1'b1;
        run_trial(5, 3, 0, 0);

        run_trial(5, 7, 0, 0);
        run_trial(2, 7, 0, 0);
        run_trial(3, 9, 0, 0);
        run_trial(4, 1, 0, 0);
        run_trial(5, 0, 0, 0);
        run_trial(5, 25, 0, 0);
        run_trial(5, 20, 0, 1);
        run_trial(6, 21, 0, 0);

        // Reset pulse in the middle of an echo.
        bus.dist_cm_i = 8'd7;
        drive_trig(5, e);
        wait_until(e + T_DLY + 5);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_echo", int'(bus.echo_o), 0);
        check("midrst_busy", int'(bus.busy_o), 0);
        rst_n = 1'b1;
        run_trial(5, 7, 0, 0);

        // Enable dropped during the burst delay.
        n = n_rise;
        bus.dist_cm_i = 8'd9;
        drive_trig(5, e);
        wait_until(e + 3);
        bus.ena = 1'b0;
        @(posedge clk);
        #1;
        check("ena_busy", int'(bus.busy_o), 0);
        check("ena_echo", int'(bus.echo_o), 0);
        wait_until(e + T_DLY + 40);
        check("ena_no_echo", n_rise - n, 0);
        bus.ena = 1'b1;
        @(posedge clk);
        #1;

        run_trial(5, 12, 1, 0);

        for (int i = 0; i < 14; i++) begin
            n = $urandom_range(1, 7);
            d = $urandom_range(0, 26);
            run_trial(n, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_until(cyc + $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
